// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU ops, condition
// codes, decode fields and data-path select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_UNDEF  = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic       SRCA_RD1  = 1'b0;
  localparam logic       SRCA_PC   = 1'b1;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic cmd_valid(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP) ||
           (cmd == CMD_AND) || (cmd == CMD_ORR);
  endfunction

  function automatic logic [1:0] cmd_alu(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register with condition-execute evaluation; flag updates only land
// when the current instruction's condition passes.
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       upd_nz,
  input  logic       upd_cv,
  output logic       cex
);

  logic [3:0] flags;
  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0;
    end else begin
      if (upd_nz && cex) flags[3:2] <= alu_flags[3:2];
      if (upd_cv && cex) flags[1:0] <= alu_flags[1:0];
    end
  end

  always_comb begin
    cex = 1'b0;
    case (cond)
      COND_EQ: cex = z;
      COND_NE: cex = !z;
      COND_CS: cex = c;
      COND_CC: cex = !c;
      COND_MI: cex = n;
      COND_PL: cex = !n;
      COND_VS: cex = v;
      COND_VC: cex = !v;
      COND_HI: cex = c && !z;
      COND_LS: cex = !c || z;
      COND_GE: cex = (n == v);
      COND_LT: cex = (n != v);
      COND_GT: cex = !z && (n == v);
      COND_LE: cex = z || (n != v);
      COND_AL: cex = 1'b1;
      default: cex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the ARM-subset data path: instruction sequencing,
// enable/select decode, memory wait timeout and condition-gated writes.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic       undef,
  output logic       mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0]    cmd;
  logic          cex, is_cmp, is_exec, rd_pc, mem_wait, expire, wr_ok;
  logic          pc_w, mem_w, ir_w, reg_w, undef_s, upd_nz, upd_cv;

  assign cmd      = funct[4:1];
  assign is_cmp   = (cmd == CMD_CMP);
  assign is_exec  = (state == S_EXECR) || (state == S_EXECI);
  assign rd_pc    = (rd == 4'hF);
  assign mem_wait = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !mem_ready;
  assign expire   = mem_wait && (cnt == CW'(MEM_TIMEOUT - 1));

  // CMP implies S; carry/overflow are only meaningful for the arithmetic commands
  assign upd_nz = is_exec && (op == OP_DP) && cmd_valid(cmd) && (funct[0] || is_cmp);
  assign upd_cv = upd_nz && ((cmd == CMD_ADD) || (cmd == CMD_SUB) || is_cmp);

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (alu_flags),
    .upd_nz    (upd_nz),
    .upd_cv    (upd_cv),
    .cex       (cex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (mem_wait && !expire) ? cnt + CW'(1) : '0;
      if (expire) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_DP:   state_n = funct[5] ? S_EXECI : S_EXECR;
          OP_MEM:  state_n = S_MEMADR;
          OP_BR:   state_n = S_BRANCH;
          default: state_n = S_UNDEF;
        endcase
      end
      S_MEMADR: state_n = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_n = S_FETCH;
      S_EXECR, S_EXECI: state_n = cmd_valid(cmd) ? S_ALUWB : S_UNDEF;
      default:  state_n = S_FETCH;
    endcase
    if (expire) state_n = S_FETCH;
  end

  always_comb begin
    pc_w        = 1'b0;
    mem_w       = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    undef_s     = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_RD1;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_ADD;
    case (state)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_w       = mem_ready;
        pc_w       = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
      end
      S_MEMADR: alu_src_b = SRCB_IMM;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_RDATA;
        if (rd_pc) pc_w = cex;
        else       reg_w = cex;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = cex;
      end
      S_EXECR: alu_control = cmd_alu(cmd);
      S_EXECI: begin
        alu_src_b   = SRCB_IMM;
        alu_control = cmd_alu(cmd);
      end
      S_ALUWB: begin
        if (!is_cmp) begin
          if (rd_pc) pc_w = cex;
          else       reg_w = cex;
        end
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_w       = cex;
      end
      S_UNDEF: undef_s = 1'b1;
      default: ;
    endcase
  end

  assign wr_ok     = !reset && !expire;
  assign pc_write  = pc_w  && wr_ok;
  assign mem_write = mem_w && wr_ok;
  assign ir_write  = ir_w  && wr_ok;
  assign reg_write = reg_w && wr_ok;
  assign undef     = undef_s && !reset;

  assign imm_src = (op == OP_UND) ? 2'b00 : op;
  assign reg_src = {(op == OP_MEM) && !funct[0], op == OP_BR};

endmodule
